// File: rtl/nw_ctrl_fsm.sv
// Needleman-Wunsch sequencing controller: matrix init, read/fill per cell, traceback.
// Optional cycle counter output enabled by defining NW_CYCLE_CNT_EN.
module nw_ctrl_fsm #(
    parameter int N_LEN = 4,
    parameter int M_LEN = 3,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rd_valid,
    input  logic             tb_step,
    input  logic [1:0]       tb_dir,
    output logic             we,
    output logic             en_init,
    output logic             en_ins,
    output logic             en_read,
    output logic             en_traceB,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
`ifdef NW_CYCLE_CNT_EN
    output logic [31:0]      cycle_cnt,
`endif
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_INIT  = 3'b001,
        S_READ  = 3'b010,
        S_FILL  = 3'b011,
        S_TRACE = 3'b100,
        S_DONE  = 3'b101
    } state_t;

    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_LEN);
    localparam logic [IDX_W-1:0] M_IDX    = IDX_W'(M_LEN);

    state_t           state_r;
    state_t           state_n_s;
    logic [IDX_W-1:0] row_r;
    logic [IDX_W-1:0] col_r;
    logic [IDX_W-1:0] row_n_s;
    logic [IDX_W-1:0] col_n_s;
    logic [IDX_W-1:0] trow_s;
    logic [IDX_W-1:0] tcol_s;

    logic we_r, en_init_r, en_ins_r, en_read_r, en_traceb_r, busy_r, done_r;
    logic we_n_s, en_init_n_s, en_ins_n_s, en_read_n_s, en_traceb_n_s, busy_n_s, done_n_s;

    // Traceback moves never wrap below row/col 0.
    function automatic logic [IDX_W-1:0] dec_sat(input logic [IDX_W-1:0] v);
        if (v == ZERO_IDX) begin
            dec_sat = ZERO_IDX;
        end else begin
            dec_sat = v - ONE_IDX;
        end
    endfunction

    // Next-state and next-index logic; abort overrides everything outside IDLE.
    always_comb begin
        state_n_s = state_r;
        row_n_s   = row_r;
        col_n_s   = col_r;
        trow_s    = row_r;
        tcol_s    = col_r;
        if (abort && (state_r != S_IDLE)) begin
            state_n_s = S_IDLE;
            row_n_s   = ZERO_IDX;
            col_n_s   = ZERO_IDX;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_n_s = S_INIT;
                        row_n_s   = ZERO_IDX;
                        col_n_s   = ZERO_IDX;
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end
                // Row 0 left to right, then column 0 top to bottom.
                S_INIT: begin
                    if ((row_r == ZERO_IDX) && (col_r != M_IDX)) begin
                        col_n_s = col_r + ONE_IDX;
                    end else if (row_r == ZERO_IDX) begin
                        row_n_s = ONE_IDX;
                        col_n_s = ZERO_IDX;
                    end else if (row_r != N_IDX) begin
                        row_n_s = row_r + ONE_IDX;
                    end else begin
                        state_n_s = S_READ;
                        row_n_s   = ONE_IDX;
                        col_n_s   = ONE_IDX;
                    end
                end
                S_READ: begin
                    if (rd_valid) begin
                        state_n_s = S_FILL;
                    end else begin
                        state_n_s = S_READ;
                    end
                end
                S_FILL: begin
                    if ((row_r == N_IDX) && (col_r == M_IDX)) begin
                        state_n_s = S_TRACE;
                    end else if (col_r == M_IDX) begin
                        state_n_s = S_READ;
                        row_n_s   = row_r + ONE_IDX;
                        col_n_s   = ONE_IDX;
                    end else begin
                        state_n_s = S_READ;
                        col_n_s   = col_r + ONE_IDX;
                    end
                end
                S_TRACE: begin
                    if ((row_r == ZERO_IDX) && (col_r == ZERO_IDX)) begin
                        state_n_s = S_DONE;
                    end else if (tb_step) begin
                        case (tb_dir)
                            2'b00: begin
                                trow_s = dec_sat(row_r);
                                tcol_s = dec_sat(col_r);
                            end
                            2'b01: trow_s = dec_sat(row_r);
                            2'b10: tcol_s = dec_sat(col_r);
                            default: begin
                                trow_s = row_r;
                                tcol_s = col_r;
                            end
                        endcase
                        row_n_s = trow_s;
                        col_n_s = tcol_s;
                        if ((trow_s == ZERO_IDX) && (tcol_s == ZERO_IDX)) begin
                            state_n_s = S_DONE;
                        end else begin
                            state_n_s = S_TRACE;
                        end
                    end else begin
                        state_n_s = S_TRACE;
                    end
                end
                S_DONE: begin
                    state_n_s = S_IDLE;
                end
                default: begin
                    state_n_s = S_IDLE;
                    row_n_s   = ZERO_IDX;
                    col_n_s   = ZERO_IDX;
                end
            endcase
        end
    end

    // State and matrix index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            row_r   <= ZERO_IDX;
            col_r   <= ZERO_IDX;
        end else begin
            state_r <= state_n_s;
            row_r   <= row_n_s;
            col_r   <= col_n_s;
        end
    end

    // Decode the upcoming state so the registered enables line up with state_r.
    always_comb begin
        we_n_s        = 1'b0;
        en_init_n_s   = 1'b0;
        en_ins_n_s    = 1'b0;
        en_read_n_s   = 1'b0;
        en_traceb_n_s = 1'b0;
        busy_n_s      = 1'b0;
        done_n_s      = 1'b0;
        case (state_n_s)
            S_IDLE: begin
                busy_n_s = 1'b0;
            end
            S_INIT: begin
                we_n_s      = 1'b1;
                en_init_n_s = 1'b1;
                busy_n_s    = 1'b1;
            end
            S_READ: begin
                en_read_n_s = 1'b1;
                busy_n_s    = 1'b1;
            end
            S_FILL: begin
                we_n_s     = 1'b1;
                en_ins_n_s = 1'b1;
                busy_n_s   = 1'b1;
            end
            S_TRACE: begin
                en_traceb_n_s = 1'b1;
                busy_n_s      = 1'b1;
            end
            S_DONE: begin
                done_n_s = 1'b1;
                busy_n_s = 1'b1;
            end
            default: begin
                busy_n_s = 1'b0;
            end
        endcase
    end

    // Registered Moore outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_r        <= 1'b0;
            en_init_r   <= 1'b0;
            en_ins_r    <= 1'b0;
            en_read_r   <= 1'b0;
            en_traceb_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            we_r        <= we_n_s;
            en_init_r   <= en_init_n_s;
            en_ins_r    <= en_ins_n_s;
            en_read_r   <= en_read_n_s;
            en_traceb_r <= en_traceb_n_s;
            busy_r      <= busy_n_s;
            done_r      <= done_n_s;
        end
    end

`ifdef NW_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_r;

    // Busy-cycle counter: cleared on launch, saturating, held while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_r <= 32'd0;
        end else if (busy_r) begin
            if (cycle_cnt_r != 32'hFFFF_FFFF) begin
                cycle_cnt_r <= cycle_cnt_r + 32'd1;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
        end else if ((state_r == S_IDLE) && start) begin
            cycle_cnt_r <= 32'd0;
        end else begin
            cycle_cnt_r <= cycle_cnt_r;
        end
    end

    assign cycle_cnt = cycle_cnt_r;
`endif

    assign we        = we_r;
    assign en_init   = en_init_r;
    assign en_ins    = en_ins_r;
    assign en_read   = en_read_r;
    assign en_traceB = en_traceb_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign row_idx   = row_r;
    assign col_idx   = col_r;
    assign state     = state_r;

endmodule

// File: tb/tb_nw_ctrl_fsm.sv
// Scoreboard bench for nw_ctrl_fsm: queue-based reference model, per-cycle monitor.
module tb_nw_ctrl_fsm;
    localparam int N = 4;
    localparam int M = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0, abort = 1'b0, rd_valid = 1'b0, tb_step = 1'b0;
    logic [1:0]   tb_dir = 2'b00;
    logic         we, en_init, en_ins, en_read, en_traceB, busy, done;
    logic [W-1:0] row_idx, col_idx;
    logic [2:0]   state;
    logic [31:0]  cnt_obs;
`ifdef NW_CYCLE_CNT_EN
    logic [31:0]  cycle_cnt;
    assign cnt_obs = cycle_cnt;
`else
    assign cnt_obs = 32'd0;
`endif

    nw_ctrl_fsm #(.N_LEN(N), .M_LEN(M), .IDX_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .rd_valid(rd_valid),
        .tb_step(tb_step), .tb_dir(tb_dir), .we(we), .en_init(en_init), .en_ins(en_ins),
        .en_read(en_read), .en_traceB(en_traceB), .busy(busy), .done(done),
        .row_idx(row_idx), .col_idx(col_idx),
`ifdef NW_CYCLE_CNT_EN
        .cycle_cnt(cycle_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   st;
        logic [W-1:0] r;
        logic [W-1:0] c;
        logic [6:0]   fl;   // we, en_init, en_ins, en_read, en_traceB, busy, done
        logic [31:0]  cnt;
    } snap_t;

    snap_t q[$];
    int tests = 0;
    int fails = 0;

    // Reference model: phase + current cell, with pending INIT/FILL cells kept as queues.
    int     m_ph, m_i, m_j;
    longint m_cnt;
    int     init_q[$];
    int     fill_q[$];

    function automatic snap_t model_snap();
        snap_t s;
        s.st  = 3'(m_ph);
        s.r   = W'(m_i);
        s.c   = W'(m_j);
        s.fl  = {(m_ph == 1 || m_ph == 3), (m_ph == 1), (m_ph == 3), (m_ph == 2),
                 (m_ph == 4), (m_ph != 0), (m_ph == 5)};
`ifdef NW_CYCLE_CNT_EN
        s.cnt = 32'(m_cnt);
`else
        s.cnt = 32'd0;
`endif
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.st  = state;
        s.r   = row_idx;
        s.c   = col_idx;
        s.fl  = {we, en_init, en_ins, en_read, en_traceB, busy, done};
        s.cnt = cnt_obs;
        return s;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_i = 0; m_j = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit ab, input bit rv, input bit ts, input logic [1:0] dir);
        int ph0 = m_ph;
        int c;
        if (ph0 != 0) m_cnt = (m_cnt >= 64'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
        else if (st) m_cnt = 0;
        if (ab && ph0 != 0) begin
            m_ph = 0; m_i = 0; m_j = 0;
        end else begin
            case (ph0)
                0: if (st) begin
                    init_q.delete(); fill_q.delete();
                    for (int j = 0; j <= M; j++) init_q.push_back(j);
                    for (int i = 1; i <= N; i++) init_q.push_back(i * 256);
                    for (int i = 1; i <= N; i++)
                        for (int j = 1; j <= M; j++) fill_q.push_back(i * 256 + j);
                    c = init_q.pop_front();
                    m_i = c / 256; m_j = c % 256; m_ph = 1;
                end
                1: begin
                    if (init_q.size() == 0) begin
                        m_ph = 2; m_i = fill_q[0] / 256; m_j = fill_q[0] % 256;
                    end else begin
                        c = init_q.pop_front(); m_i = c / 256; m_j = c % 256;
                    end
                end
                2: if (rv) m_ph = 3;
                3: begin
                    void'(fill_q.pop_front());
                    if (fill_q.size() == 0) m_ph = 4;
                    else begin
                        m_ph = 2; m_i = fill_q[0] / 256; m_j = fill_q[0] % 256;
                    end
                end
                4: begin
                    if (m_i == 0 && m_j == 0) m_ph = 5;
                    else if (ts) begin
                        if (dir == 2'b00 || dir == 2'b01) m_i = (m_i > 0) ? m_i - 1 : 0;
                        if (dir == 2'b00 || dir == 2'b10) m_j = (m_j > 0) ? m_j - 1 : 0;
                        if (m_i == 0 && m_j == 0) m_ph = 5;
                    end
                end
                default: m_ph = 0;
            endcase
        end
    endtask

    // One stimulus cycle: drive at the falling edge, push the expected post-edge snapshot.
    task automatic cyc(input bit st, input bit ab, input bit rv, input bit ts, input logic [1:0] dir);
        @(negedge clk);
        rst = 1'b1; start = st; abort = ab; rd_valid = rv; tb_step = ts; tb_dir = dir;
        model_step(st, ab, rv, ts, dir);
        q.push_back(model_snap());
    endtask

    task automatic check_now(input string name, input snap_t a, input snap_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s t=%0t actual st=%0d r=%0d c=%0d fl=%b cnt=%0d required st=%0d r=%0d c=%0d fl=%b cnt=%0d",
                     name, $time, a.st, a.r, a.c, a.fl, a.cnt, e.st, e.r, e.c, e.fl, e.cnt);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge once stimulus has begun.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_now("cycle", dut_snap(), e);
            end
        end
    end

    initial begin
        logic [1:0] dirs [4];
        int k;
        int guard;
        dirs[0] = 2'b00; dirs[1] = 2'b00; dirs[2] = 2'b00; dirs[3] = 2'b01;
        model_reset();
        #1;
        check_now("reset_state", dut_snap(), model_snap());

        // Full run: rd_valid and tb_step held high, traceback diag,diag,diag,up.
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        k = 0; guard = 0;
        while (m_ph != 0 && guard < 200) begin
            if (m_ph == 4 && k < 4) begin
                cyc(1'b0, 1'b0, 1'b1, 1'b1, dirs[k]); k++;
            end else begin
                cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
            end
            guard++;
        end
        tests++;
        if (guard >= 200 || k != 4) begin
            fails++;
            $display("FAIL directed_run_bound guard=%0d moves=%0d required moves=4", guard, k);
        end
`ifdef NW_CYCLE_CNT_EN
        @(posedge clk); #1;
        tests++;
        if (cycle_cnt !== 32'd37) begin
            fails++;
            $display("FAIL cycle_cnt_total actual=%0d required=37", cycle_cnt);
        end
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        // start held high through the run (ignored once busy); abort in READ at (2,2).
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        guard = 0;
        while (!(m_ph == 2 && m_i == 2 && m_j == 2) && guard < 200) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b00); guard++;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'b00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);

        // Asynchronous reset asserted while in FILL.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        guard = 0;
        while (m_ph != 3 && guard < 200) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'b00); guard++;
        end
        @(negedge clk);
        #2;
        rst = 1'b0; start = 1'b0; abort = 1'b0; rd_valid = 1'b0; tb_step = 1'b0;
        #1;
        model_reset();
        check_now("async_reset_fill", dut_snap(), model_snap());
        q.push_back(model_snap());

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        @(posedge clk); #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
